sobolrng_arb: RTL and testbench

Round-robin arbiter and run sequencer that shares one Sobol RNG index counter among NREQ stochastic-bitstream consumers. A granted requester receives one full Sobol period of 2^BITWIDTH indices (0 … 2^BITWIDTH−1), with per-cycle stall support, followed by a done pulse. The block owns the index counter. oCntEn/oIdx present the same enable/count contract as the counter feeding the Sobol direction-vector logic, so the downstream RNG needs no counter of its own. It sits between the requesting compute units and the shared sobolrng datapath.

---
 rtl/sobolrng_arb.sv | 142 ++++++++++++++
 tb/tb_sobolrng_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobolrng_arb.sv
// sobolrng_arb: round-robin arbiter and run sequencer that owns the shared
// Sobol index counter. A granted requester gets one full period of
// 2^BITWIDTH enabled beats (stallable via iHold), followed by a one-cycle
// done pulse. A dropped request aborts the run without a done pulse.
module sobolrng_arb #(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic [NREQ-1:0]     iReq,
  input  logic                iHold,
  output logic [NREQ-1:0]     oGnt,
  output logic                oCntEn,
  output logic [BITWIDTH-1:0] oIdx,
  output logic                oLast,
  output logic [NREQ-1:0]     oDone
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [BITWIDTH-1:0] IDX_MAX  = {BITWIDTH{1'b1}};
  localparam logic [PW-1:0]       PTR_INIT = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] sel);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[sel] = 1'b1;
    return v;
  endfunction

  state_t              state_r, state_s;
  logic [PW-1:0]       ptr_r, ptr_s;
  logic [NREQ-1:0]     gnt_r, gnt_s;
  logic [BITWIDTH-1:0] idx_r, idx_s;
  logic [NREQ-1:0]     done_r, done_s;

  logic [PW-1:0]       win_s;
  logic [PW-1:0]       cand_s;
  logic                found_s;
  logic                req_g_s;
  logic                cnt_en_s;
  logic                last_s;

  // ptr always holds the granted index while a run is active.
  assign req_g_s  = iReq[ptr_r];
  assign cnt_en_s = (state_r == RUN) & ~iHold & req_g_s;
  assign last_s   = cnt_en_s & (idx_r == IDX_MAX);

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    found_s = 1'b0;
    win_s   = {PW{1'b0}};
    cand_s  = {PW{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = PW'((int'(ptr_r) + i) % NREQ);
      if (!found_s && iReq[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Sequencer next-state: arbitration, beat counting, completion and abort.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gnt_s   = gnt_r;
    idx_s   = idx_r;
    done_s  = {NREQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (found_s) begin
          gnt_s   = onehot(win_s);
          ptr_s   = win_s;
          idx_s   = {BITWIDTH{1'b0}};
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!req_g_s) begin
          // Abort: requester withdrew, no completion pulse.
          gnt_s   = {NREQ{1'b0}};
          idx_s   = {BITWIDTH{1'b0}};
          state_s = IDLE;
        end else if (last_s) begin
          gnt_s   = {NREQ{1'b0}};
          idx_s   = {BITWIDTH{1'b0}};
          done_s  = onehot(ptr_r);
          state_s = DONE;
        end else if (cnt_en_s) begin
          idx_s = idx_r + {{(BITWIDTH-1){1'b0}}, 1'b1};
        end else begin
          idx_s = idx_r;
        end
      end
      DONE: begin
        gnt_s   = {NREQ{1'b0}};
        state_s = IDLE;
      end
      default: begin
        gnt_s   = {NREQ{1'b0}};
        idx_s   = {BITWIDTH{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_r <= IDLE;
      ptr_r   <= PTR_INIT;
      gnt_r   <= {NREQ{1'b0}};
      idx_r   <= {BITWIDTH{1'b0}};
      done_r  <= {NREQ{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gnt_r   <= gnt_s;
      idx_r   <= idx_s;
      done_r  <= done_s;
    end
  end

  assign oGnt   = gnt_r;
  assign oIdx   = idx_r;
  assign oDone  = done_r;
  assign oCntEn = cnt_en_s;
  assign oLast  = last_s;

endmodule

// File: tb/tb_sobolrng_arb.sv
// Scoreboard bench for sobolrng_arb (BITWIDTH=4, NREQ=4, 16-beat runs).
// Stimulus pushes expected beat/done events; a negedge monitor pops and
// compares whenever the DUT shows oCntEn or a done pulse.
module tb_sobolrng_arb;
  localparam int BW = 4;
  localparam int NR = 4;

  logic          iClk;
  logic          iRstN;
  logic [NR-1:0] iReq;
  logic          iHold;
  logic [NR-1:0] oGnt;
  logic          oCntEn;
  logic [BW-1:0] oIdx;
  logic          oLast;
  logic [NR-1:0] oDone;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_cyc = -1;
  bit gap_chk  = 1'b0;
  logic [13:0] exp_q[$];

  sobolrng_arb #(.BITWIDTH(BW), .NREQ(NR)) dut (
    .iClk(iClk), .iRstN(iRstN), .iReq(iReq), .iHold(iHold),
    .oGnt(oGnt), .oCntEn(oCntEn), .oIdx(oIdx), .oLast(oLast), .oDone(oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // free-running cycle stamp
  always @(posedge iClk) cyc <= cyc + 1;

  function automatic logic [13:0] pack(input logic en, input logic [3:0] g,
                                       input logic [3:0] idx, input logic last,
                                       input logic [3:0] d);
    return {en, g, idx, last, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected beats idx first..first+n-1 of grant g, optionally the done pulse
  task automatic push_run(input logic [3:0] g, input int first, input int n, input bit with_done);
    for (int k = first; k < first + n; k++) begin
      logic [3:0] ix;
      ix = 4'(k);
      exp_q.push_back(pack(1'b1, g, ix, (ix == 4'd15), 4'd0));
    end
    if (with_done) exp_q.push_back(pack(1'b0, 4'd0, 4'd0, 1'b0, g));
  endtask

  // monitor: compare every presented beat / done pulse against the scoreboard
  always @(negedge iClk) begin
    if (iRstN && (oCntEn || oDone != 4'd0)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event actual=%0h required=none",
                 pack(oCntEn, oGnt, oIdx, oLast, oDone));
      end else begin
        chk("event", 32'(pack(oCntEn, oGnt, oIdx, oLast, oDone)), 32'(exp_q.pop_front()));
      end
      if (gap_chk && oCntEn && oIdx == 4'd0 && last_cyc >= 0)
        chk("b2b_gap", 32'(cyc - last_cyc), 32'd3);
      if (!gap_chk) last_cyc <= -1;
      else if (oLast) last_cyc <= cyc;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge iClk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    iReq  = 4'd0;
    iHold = 1'b0;
    @(negedge iClk);
    chk("rst_gnt",  32'(oGnt),   32'd0);
    chk("rst_done", 32'(oDone),  32'd0);
    chk("rst_idx",  32'(oIdx),   32'd0);
    chk("rst_en",   32'(oCntEn), 32'd0);
    chk("rst_last", 32'(oLast),  32'd0);
    iRstN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    iRstN = 1'b0;
    iReq  = 4'd0;
    iHold = 1'b0;

    // 1: single requester, full run
    do_reset();
    @(posedge iClk); #1;
    iReq = 4'b0001;
    push_run(4'b0001, 0, 16, 1'b1);
    @(negedge iClk);
    chk("gnt_before", 32'(oGnt), 32'd0);
    @(negedge iClk);
    chk("gnt_latency", 32'(oGnt), 32'b0001);
    drain();
    #1 iReq = 4'd0;

    // 2: all requesting, round-robin order and back-to-back gaps
    do_reset();
    @(posedge iClk); #1;
    gap_chk = 1'b1;
    iReq = 4'b1111;
    push_run(4'b0001, 0, 16, 1'b1);
    push_run(4'b0010, 0, 16, 1'b1);
    push_run(4'b0100, 0, 16, 1'b1);
    push_run(4'b1000, 0, 16, 1'b1);
    push_run(4'b0001, 0, 16, 1'b1);
    drain();
    #1 iReq = 4'd0;
    gap_chk = 1'b0;

    // 3: hold for 5 cycles at idx 3
    do_reset();
    @(posedge iClk); #1;
    t0 = cyc;
    iReq = 4'b0001;
    push_run(4'b0001, 0, 16, 1'b1);
    repeat (4) @(posedge iClk);
    #1 iHold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      chk("hold_en",  32'(oCntEn), 32'd0);
      chk("hold_idx", 32'(oIdx),   32'd3);
      @(posedge iClk);
    end
    #1 iHold = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge iClk);
      n++;
      if (oDone != 4'd0) break;
    end
    chk("done_time", 32'(cyc - t0), 32'd22);
    drain();
    #1 iReq = 4'd0;

    // 4: requester 2 aborts at idx 7, pending requester 3 follows
    do_reset();
    @(posedge iClk); #1;
    iReq = 4'b1100;
    push_run(4'b0100, 0, 7, 1'b0);
    repeat (8) @(posedge iClk);
    #1 iReq = 4'b1000;
    push_run(4'b1000, 0, 16, 1'b1);
    @(negedge iClk);
    chk("abort_en",  32'(oCntEn), 32'd0);
    chk("abort_idx", 32'(oIdx),   32'd7);
    chk("abort_gnt", 32'(oGnt),   32'b0100);
    @(negedge iClk);
    chk("idle_gnt",  32'(oGnt),  32'd0);
    chk("idle_idx",  32'(oIdx),  32'd0);
    chk("idle_done", 32'(oDone), 32'd0);
    @(negedge iClk);
    chk("next_gnt", 32'(oGnt), 32'b1000);
    drain();
    #1 iReq = 4'd0;

    // 5: asynchronous reset mid-run at idx 9
    do_reset();
    @(posedge iClk); #1;
    iReq = 4'b0010;
    push_run(4'b0010, 0, 9, 1'b0);
    repeat (10) @(posedge iClk);
    #1;
    chk("pre_rst_idx", 32'(oIdx), 32'd9);
    iRstN = 1'b0;
    #1;
    chk("arst_gnt",  32'(oGnt),   32'd0);
    chk("arst_idx",  32'(oIdx),   32'd0);
    chk("arst_en",   32'(oCntEn), 32'd0);
    chk("arst_last", 32'(oLast),  32'd0);
    chk("arst_done", 32'(oDone),  32'd0);
    @(negedge iClk);
    iRstN = 1'b1;
    push_run(4'b0010, 0, 16, 1'b1);
    drain();
    #1 iReq = 4'd0;

    // 6: requesters 1 and 3 alternate
    do_reset();
    @(posedge iClk); #1;
    iReq = 4'b1010;
    push_run(4'b0010, 0, 16, 1'b1);
    push_run(4'b1000, 0, 16, 1'b1);
    push_run(4'b0010, 0, 16, 1'b1);
    drain();
    #1 iReq = 4'd0;

    repeat (3) @(posedge iClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
